// File: rtl/elevator_pkg.sv
// Shared elevator types and constants.
// Used by the request queue and the elevator controller.
package elevator_pkg;

  localparam int FLOOR_W        = 4;
  localparam int NUM_FLOORS_DEF = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/elevator_request_queue_if.sv
// Button, position and target bundle around the request queue.
// slave = request queue, master = controller / button panel side.
interface elevator_request_queue_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int FW         = FLOOR_W
);

  logic [NUM_FLOORS-1:0] button_raw;
  logic [FW-1:0]         current_floor;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] floor_req;
  logic [FW-1:0]         target_floor;
  logic                  target_valid;
  logic                  dir_up;

  modport slave (
    input  button_raw,
    input  current_floor,
    input  door_open,
    output floor_req,
    output target_floor,
    output target_valid,
    output dir_up
  );

  modport master (
    output button_raw,
    output current_floor,
    output door_open,
    input  floor_req,
    input  target_floor,
    input  target_valid,
    input  dir_up
  );

endinterface

// File: rtl/elevator_request_queue_debouncer.sv
// Per-button synchroniser, optional debounce and press-edge pulse.
// Debounce stage present only when REQ_DEBOUNCE_EN is defined.
module req_debouncer
`ifdef REQ_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic press
);

  logic s1;
  logic s2;
  logic lvl;
  logic lvl_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl_d <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_d <= lvl;
      press <= lvl & ~lvl_d;
    end
  end

`ifdef REQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          db;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= '0;
      db  <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign lvl = db;
`else
  assign lvl = s2;
`endif

endmodule

// File: rtl/elevator_request_queue.sv
// Pending call register, floor-served clear and SCAN target select.
// Optional button debounce enabled by defining REQ_DEBOUNCE_EN.
module elevator_request_queue
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF
`ifdef REQ_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input logic                     clk,
  input logic                     reset_n,
  elevator_request_queue_if.slave bus
);

  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] pending;
  logic [NUM_FLOORS-1:0] pending_n;
  logic [NUM_FLOORS-1:0] clr;
  logic [FLOOR_W-1:0]    cur;
  logic                  in_range;

  logic [FLOOR_W-1:0]    tgt_q;
  logic [FLOOR_W-1:0]    tgt_n;
  logic                  vld_q;
  logic                  vld_n;
  dir_e                  dir_q;
  dir_e                  dir_n;

  logic                  up_hit;
  logic                  dn_hit;
  logic                  here;
  logic [FLOOR_W-1:0]    up_idx;
  logic [FLOOR_W-1:0]    dn_idx;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    req_debouncer
`ifdef REQ_DEBOUNCE_EN
    #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    )
`endif
    u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (bus.button_raw[g]),
      .press  (press[g])
    );
  end

  assign cur = bus.current_floor;
  assign in_range =
    {1'b0, cur} < (FLOOR_W + 1)'(NUM_FLOORS);

  always_comb begin
    clr = '0;
    if (bus.door_open && in_range) begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (cur == FLOOR_W'(i)) clr[i] = 1'b1;
      end
    end
  end

  // Clear beats a same-cycle press on the served floor
  assign pending_n = (pending | press) & ~clr;

  always_comb begin
    up_hit = 1'b0;
    up_idx = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && FLOOR_W'(i) > cur) begin
        up_hit = 1'b1;
        up_idx = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    dn_hit = 1'b0;
    dn_idx = '0;
    here   = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && FLOOR_W'(i) < cur) begin
        dn_hit = 1'b1;
        dn_idx = FLOOR_W'(i);
      end
      if (pending[i] && FLOOR_W'(i) == cur) here = 1'b1;
    end
  end

  always_comb begin
    tgt_n = tgt_q;
    vld_n = 1'b0;
    dir_n = dir_q;
    if (in_range && (|pending)) begin
      vld_n = 1'b1;
      if (dir_q == DIR_UP) begin
        if (up_hit) begin
          tgt_n = up_idx;
        end else if (dn_hit) begin
          tgt_n = dn_idx;
          dir_n = DIR_DOWN;
        end else if (here) begin
          tgt_n = cur;
        end
      end else begin
        if (dn_hit) begin
          tgt_n = dn_idx;
        end else if (up_hit) begin
          tgt_n = up_idx;
          dir_n = DIR_UP;
        end else if (here) begin
          tgt_n = cur;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      tgt_q   <= '0;
      vld_q   <= 1'b0;
      dir_q   <= DIR_UP;
    end else begin
      pending <= pending_n;
      tgt_q   <= tgt_n;
      vld_q   <= vld_n;
      dir_q   <= dir_n;
    end
  end

  assign bus.floor_req    = pending;
  assign bus.target_floor = tgt_q;
  assign bus.target_valid = vld_q;
  assign bus.dir_up       = (dir_q == DIR_UP);

endmodule

// File: tb/tb_elevator_request_queue.sv
// Bench for elevator_request_queue: directed scenarios plus random
// traffic against a floor-list SCAN reference model.
module tb_elevator_request_queue;
  import elevator_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  elevator_request_queue_if #(
    .NUM_FLOORS(4),
    .FW        (FLOOR_W)
  ) bus ();

  elevator_request_queue dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Reference state: raw samples seen at recent edges, requests, target
  logic [3:0] hist [4];
  logic [3:0] m_pend;
  logic [3:0] m_tgt;
  logic       m_vld;
  logic       m_dir;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) hist[k] = 4'h0;
    m_pend = 4'h0;
    m_tgt  = 4'h0;
    m_vld  = 1'b0;
    m_dir  = 1'b1;
  endtask

  // Advance one clock, updating the reference from pre-edge values
  task automatic tick();
    logic [3:0] prs;
    logic [3:0] clr;
    logic [3:0] np;
    logic [3:0] nt;
    logic       nv;
    logic       nd;
    int         c;
    int         up;
    int         dn;
    prs = hist[2] & ~hist[3];
    c   = int'(bus.current_floor);
    clr = 4'h0;
    if (bus.door_open && c < 4) clr[c] = 1'b1;
    np = (m_pend | prs) & ~clr;
    nt = m_tgt;
    nv = 1'b0;
    nd = m_dir;
    if (c < 4 && m_pend != 4'h0) begin
      up = -1;
      dn = -1;
      for (int d = 1; d < 4; d++) begin
        if (up < 0 && c + d < 4)
          if (m_pend[c+d]) up = c + d;
        if (dn < 0 && c - d >= 0)
          if (m_pend[c-d]) dn = c - d;
      end
      nv = 1'b1;
      if (m_dir) begin
        if (up >= 0) nt = 4'(up);
        else if (dn >= 0) begin
          nt = 4'(dn);
          nd = 1'b0;
        end else nt = 4'(c);
      end else begin
        if (dn >= 0) nt = 4'(dn);
        else if (up >= 0) begin
          nt = 4'(up);
          nd = 1'b1;
        end else nt = 4'(c);
      end
    end
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = bus.button_raw;
      m_pend  = np;
      m_tgt   = nt;
      m_vld   = nv;
      m_dir   = nd;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n           = 1'b0;
    bus.button_raw    = 4'h0;
    bus.door_open     = 1'b0;
    bus.current_floor = 4'd0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n           = 1'b0;
    bus.button_raw    = 4'hF;
    bus.door_open     = 1'b0;
    bus.current_floor = 4'd0;
    repeat (3) tick();
    checks++;
    if (bus.floor_req !== 4'h0) begin
      failures++;
      $display("FAIL rst_req got=%h exp=0", bus.floor_req);
    end
    checks++;
    if (bus.target_floor !== 4'h0) begin
      failures++;
      $display("FAIL rst_tgt got=%h exp=0", bus.target_floor);
    end
    checks++;
    if (bus.target_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_vld got=%b exp=0", bus.target_valid);
    end
    checks++;
    if (bus.dir_up !== 1'b1) begin
      failures++;
      $display("FAIL rst_dir got=%b exp=1", bus.dir_up);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (bus.floor_req !== ((k >= 4) ? 4'hF : 4'h0)) begin
        failures++;
        $display("FAIL held_req k=%0d got=%h", k, bus.floor_req);
      end
    end
    bus.door_open = 1'b1;
    tick();
    bus.door_open = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.floor_req !== 4'hE) begin
      failures++;
      $display("FAIL no_retrig got=%h exp=e", bus.floor_req);
    end
    bus.button_raw = 4'h0;
  endtask

  task automatic test_set_serve();
    do_reset();
    bus.button_raw = 4'b0100;
    tick();
    bus.button_raw = 4'h0;
    repeat (3) tick();
    checks++;
    if (bus.floor_req !== 4'b0100) begin
      failures++;
      $display("FAIL ss_req got=%h exp=4", bus.floor_req);
    end
    tick();
    checks++;
    if ({bus.target_floor, bus.target_valid, bus.dir_up}
        !== {4'd2, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL ss_tgt got=%h/%b/%b exp=2/1/1",
               bus.target_floor, bus.target_valid, bus.dir_up);
    end
    bus.current_floor = 4'd2;
    bus.door_open     = 1'b1;
    tick();
    checks++;
    if (bus.floor_req !== 4'h0) begin
      failures++;
      $display("FAIL ss_clr got=%h exp=0", bus.floor_req);
    end
    tick();
    checks++;
    if (bus.target_valid !== 1'b0) begin
      failures++;
      $display("FAIL ss_vld got=%b exp=0", bus.target_valid);
    end
    bus.door_open = 1'b0;
  endtask

  task automatic test_scan();
    do_reset();
    bus.current_floor = 4'd1;
    bus.button_raw    = 4'b1001;
    tick();
    bus.button_raw = 4'h0;
    repeat (4) tick();
    checks++;
    if ({bus.target_floor, bus.dir_up} !== {4'd3, 1'b1}) begin
      failures++;
      $display("FAIL scan_up got=%h/%b exp=3/1",
               bus.target_floor, bus.dir_up);
    end
    bus.current_floor = 4'd3;
    bus.door_open     = 1'b1;
    tick();
    bus.door_open = 1'b0;
    tick();
    checks++;
    if ({bus.floor_req, bus.target_floor,
         bus.target_valid, bus.dir_up}
        !== {4'b0001, 4'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL scan_flip got=%h/%h/%b/%b exp=1/0/1/0",
               bus.floor_req, bus.target_floor,
               bus.target_valid, bus.dir_up);
    end
  endtask

  task automatic test_collision();
    do_reset();
    bus.current_floor = 4'd1;
    bus.button_raw    = 4'b0010;
    tick();
    bus.button_raw = 4'h0;
    tick();
    tick();
    bus.door_open = 1'b1;
    tick();
    checks++;
    if (bus.floor_req[1] !== 1'b0) begin
      failures++;
      $display("FAIL collide got=%b exp=0", bus.floor_req[1]);
    end
    bus.door_open = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.floor_req, bus.target_valid} !== 5'h0) begin
      failures++;
      $display("FAIL collide_after got=%h/%b exp=0/0",
               bus.floor_req, bus.target_valid);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    bus.current_floor = 4'd1;
    bus.button_raw    = 4'b0010;
    tick();
    bus.button_raw = 4'h0;
    repeat (4) tick();
    checks++;
    if (bus.target_valid !== 1'b1) begin
      failures++;
      $display("FAIL oor_pre got=%b exp=1", bus.target_valid);
    end
    bus.current_floor = 4'd9;
    bus.door_open     = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.floor_req, bus.target_valid,
         bus.dir_up, bus.target_floor}
        !== {4'b0010, 1'b0, 1'b1, 4'd1}) begin
      failures++;
      $display("FAIL oor got=%h/%b/%b/%h exp=2/0/1/1",
               bus.floor_req, bus.target_valid,
               bus.dir_up, bus.target_floor);
    end
    bus.door_open = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0)
        bus.button_raw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0)
        bus.current_floor = ($urandom_range(0, 9) == 0)
          ? 4'($urandom_range(4, 15))
          : 4'($urandom_range(0, 3));
      bus.door_open = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if ({bus.floor_req, bus.target_floor,
           bus.target_valid, bus.dir_up}
          !== {m_pend, m_tgt, m_vld, m_dir}) begin
        failures++;
        $display("FAIL rand n=%0d got=%h/%h/%b/%b exp=%h/%h/%b/%b",
                 n, bus.floor_req, bus.target_floor,
                 bus.target_valid, bus.dir_up,
                 m_pend, m_tgt, m_vld, m_dir);
      end
    end
    bus.button_raw = 4'h0;
    bus.door_open  = 1'b0;
  endtask

`ifdef REQ_DEBOUNCE_EN
  task automatic test_debounce();
    do_reset();
    bus.current_floor = 4'd0;
    bus.button_raw    = 4'b0100;
    repeat (10) tick();
    bus.button_raw = 4'h0;
    repeat (30) tick();
    checks++;
    if (bus.floor_req !== 4'h0) begin
      failures++;
      $display("FAIL db_glitch got=%h exp=0", bus.floor_req);
    end
    bus.button_raw = 4'b0100;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 19 || k == 20) begin
        checks++;
        if (bus.floor_req !== ((k == 20) ? 4'b0100 : 4'h0)) begin
          failures++;
          $display("FAIL db_press k=%0d got=%h", k, bus.floor_req);
        end
      end
    end
    bus.button_raw = 4'h0;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
`ifdef REQ_DEBOUNCE_EN
    test_debounce();
`else
    test_set_serve();
    test_scan();
    test_collision();
    test_out_of_range();
    test_random();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
